// File: rtl/debug_link_ctrl_pkg.sv
// Shared definitions for the UART debug link: command bytes, reply bytes,
// one-hot controller states and dump source selection.
package debug_link_ctrl_pkg;

    localparam int ST_W = 10;

    localparam int S_IDLE       = 0;
    localparam int S_LOAD_IM    = 1;
    localparam int S_RUN        = 2;
    localparam int S_STEP_WAIT  = 3;
    localparam int S_STEP_EXEC  = 4;
    localparam int S_DUMP_FETCH = 5;
    localparam int S_DUMP_SEND  = 6;
    localparam int S_DUMP_WAIT  = 7;
    localparam int S_SEND_CSUM  = 8;
    localparam int S_ERROR      = 9;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE       = ST_W'(1 << S_IDLE),
        ST_LOAD_IM    = ST_W'(1 << S_LOAD_IM),
        ST_RUN        = ST_W'(1 << S_RUN),
        ST_STEP_WAIT  = ST_W'(1 << S_STEP_WAIT),
        ST_STEP_EXEC  = ST_W'(1 << S_STEP_EXEC),
        ST_DUMP_FETCH = ST_W'(1 << S_DUMP_FETCH),
        ST_DUMP_SEND  = ST_W'(1 << S_DUMP_SEND),
        ST_DUMP_WAIT  = ST_W'(1 << S_DUMP_WAIT),
        ST_SEND_CSUM  = ST_W'(1 << S_SEND_CSUM),
        ST_ERROR      = ST_W'(1 << S_ERROR)
    } state_e;

    typedef enum logic [1:0] {
        SRC_RB = 2'd0,
        SRC_DM = 2'd1,
        SRC_PC = 2'd2
    } dump_src_e;

    localparam logic [7:0] CMD_LOAD_IM   = 8'h01;
    localparam logic [7:0] CMD_RUN       = 8'h02;
    localparam logic [7:0] CMD_STEP      = 8'h03;
    localparam logic [7:0] CMD_DUMP_RB   = 8'h04;
    localparam logic [7:0] CMD_DUMP_DM   = 8'h05;
    localparam logic [7:0] CMD_DUMP_PC   = 8'h06;
    localparam logic [7:0] CMD_STEP_EXEC = 8'h07;
    localparam logic [7:0] CMD_STEP_EXIT = 8'h08;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

endpackage

// File: rtl/debug_link_ctrl_if.sv
// Byte-UART handshake between the UART (master) and the debug controller (slave).
interface debug_link_ctrl_if #(
    parameter int BYTE = 8
) ();
    logic            rx_done;
    logic [BYTE-1:0] rx_data;
    logic            tx_start;
    logic [BYTE-1:0] tx_data;
    logic            tx_done;

    modport master (
        output rx_done, rx_data, tx_done,
        input  tx_start, tx_data
    );

    modport slave (
        input  rx_done, rx_data, tx_done,
        output tx_start, tx_data
    );
endinterface

// File: rtl/debug_link_ctrl_tx_serializer.sv
// Splits a CPU word into UART bytes MS-first, runs the tx_start/tx_done
// handshake and keeps the running XOR checksum of every word byte sent.
module debug_tx_serializer
    import debug_link_ctrl_pkg::*;
#(
    parameter int BYTE  = 8,
    parameter int DWORD = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [DWORD-1:0] i_word,
    input  logic             i_send_word,
    input  logic             i_send_csum,
    input  logic             i_send_err,
    input  logic             i_clear,
    input  logic             i_tx_done,
    output logic             o_tx_start,
    output logic [BYTE-1:0]  o_tx_data,
    output logic             o_done
);

    logic [DWORD-1:0] shift_q, shift_d;
    logic [DWORD-1:0] word_src;
    logic [BYTE-1:0]  tx_data_q, tx_data_d;
    logic [BYTE-1:0]  csum_q, csum_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;

    // Loading and sending in the same cycle takes the byte straight from i_word.
    always_comb begin
        word_src   = i_load ? i_word : shift_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q & ~i_tx_done;
        if (i_clear) begin
            shift_d = '0;
            csum_d  = '0;
        end
        if (i_send_word) begin
            tx_start_d = 1'b1;
            tx_data_d  = word_src[DWORD-1 -: BYTE];
            shift_d    = word_src << BYTE;
            csum_d     = csum_q ^ word_src[DWORD-1 -: BYTE];
            busy_d     = 1'b1;
        end else if (i_send_csum) begin
            tx_start_d = 1'b1;
            tx_data_d  = csum_q;
            busy_d     = 1'b1;
        end else if (i_send_err) begin
            tx_start_d = 1'b1;
            tx_data_d  = BYTE'(ERR_BYTE);
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift_q    <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_done     = busy_q & i_tx_done;

endmodule

// File: rtl/debug_link_ctrl.sv
// UART-side debug controller: loads instruction memory, runs or single-steps
// the core and dumps register bank, data memory or PC with a checksum byte.
//
// state      | meaning
// IDLE       | waiting for a command byte
// LOAD_IM    | writing received bytes into instruction memory
// RUN        | core enabled until it halts
// STEP_WAIT  | waiting for step (0x07) or exit (0x08)
// STEP_EXEC  | core enabled for this single cycle
// DUMP_FETCH | latch the current word into the serializer, send its MS byte
// DUMP_SEND  | tx_start pulse cycle
// DUMP_WAIT  | waiting for the UART to finish the byte
// SEND_CSUM  | sending the XOR checksum and waiting for tx_done
// ERROR      | sending the error byte and waiting for tx_done
module debug_link_ctrl
    import debug_link_ctrl_pkg::*;
#(
    parameter int BYTE     = 8,
    parameter int DWORD    = 32,
    parameter int IM_BYTES = 256,
    parameter int RB_WORDS = 32,
    parameter int DM_WORDS = 32,
    parameter int ADDR     = 5,
    parameter int NB_ST    = ST_W
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    debug_link_ctrl_if.slave            uart,
    output logic                        o_im_wr_en,
    output logic [$clog2(IM_BYTES)-1:0] o_im_wr_addr,
    output logic [BYTE-1:0]             o_im_wr_data,
    input  logic                        i_cpu_halt,
    output logic                        o_cpu_enable,
    output logic [ADDR-1:0]             o_rd_addr,
    input  logic [DWORD-1:0]            i_rb_data,
    input  logic [DWORD-1:0]            i_dm_data,
    input  logic [DWORD-1:0]            i_pc,
    output logic [NB_ST-1:0]            o_state
);

    localparam int BPW = DWORD / BYTE;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IMW = $clog2(IM_BYTES);
    localparam logic [IMW-1:0] IM_LAST = IMW'(IM_BYTES - 1);

    state_e          state_q, state_d;
    dump_src_e       src_q, src_d;
    logic [ADDR-1:0] word_cnt_q, word_cnt_d;
    logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [ADDR-1:0] rd_addr_q, rd_addr_d;
    logic [IMW-1:0]  im_cnt_q, im_cnt_d;
    logic            im_wr_en_q, im_wr_en_d;
    logic [IMW-1:0]  im_wr_addr_q, im_wr_addr_d;
    logic [BYTE-1:0] im_wr_data_q, im_wr_data_d;
    logic            cpu_enable_q, cpu_enable_d;

    logic             ser_load, ser_send_word, ser_send_csum, ser_send_err, ser_clear;
    logic             ser_done;
    logic [DWORD-1:0] dump_word;

    always_comb begin
        case (src_q)
            SRC_RB:  dump_word = i_rb_data;
            SRC_DM:  dump_word = i_dm_data;
            default: dump_word = i_pc;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        word_cnt_d    = word_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        rd_addr_d     = rd_addr_q;
        im_cnt_d      = im_cnt_q;
        im_wr_en_d    = 1'b0;
        im_wr_addr_d  = im_wr_addr_q;
        im_wr_data_d  = im_wr_data_q;
        cpu_enable_d  = 1'b0;
        ser_load      = 1'b0;
        ser_send_word = 1'b0;
        ser_send_csum = 1'b0;
        ser_send_err  = 1'b0;
        ser_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (uart.rx_done) begin
                    case (uart.rx_data)
                        CMD_LOAD_IM: state_d = ST_LOAD_IM;
                        CMD_RUN: begin
                            state_d      = ST_RUN;
                            cpu_enable_d = 1'b1;
                        end
                        CMD_STEP: state_d = ST_STEP_WAIT;
                        CMD_DUMP_RB: begin
                            state_d    = ST_DUMP_FETCH;
                            src_d      = SRC_RB;
                            word_cnt_d = ADDR'(RB_WORDS - 1);
                            rd_addr_d  = '0;
                            ser_clear  = 1'b1;
                        end
                        CMD_DUMP_DM: begin
                            state_d    = ST_DUMP_FETCH;
                            src_d      = SRC_DM;
                            word_cnt_d = ADDR'(DM_WORDS - 1);
                            rd_addr_d  = '0;
                            ser_clear  = 1'b1;
                        end
                        CMD_DUMP_PC: begin
                            state_d    = ST_DUMP_FETCH;
                            src_d      = SRC_PC;
                            word_cnt_d = '0;
                            rd_addr_d  = '0;
                            ser_clear  = 1'b1;
                        end
                        default: begin
                            state_d      = ST_ERROR;
                            ser_send_err = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD_IM: begin
                if (uart.rx_done) begin
                    im_wr_en_d   = 1'b1;
                    im_wr_addr_d = im_cnt_q;
                    im_wr_data_d = uart.rx_data;
                    if (im_cnt_q == IM_LAST) begin
                        im_cnt_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        im_cnt_d = im_cnt_q + IMW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (i_cpu_halt) begin
                    state_d = ST_IDLE;
                end else begin
                    cpu_enable_d = 1'b1;
                end
            end
            ST_STEP_WAIT: begin
                if (uart.rx_done) begin
                    if (uart.rx_data == CMD_STEP_EXEC) begin
                        if (!i_cpu_halt) begin
                            state_d      = ST_STEP_EXEC;
                            cpu_enable_d = 1'b1;
                        end
                    end else if (uart.rx_data == CMD_STEP_EXIT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STEP_EXEC: state_d = ST_STEP_WAIT;
            ST_DUMP_FETCH: begin
                ser_load      = 1'b1;
                ser_send_word = 1'b1;
                byte_cnt_d    = BCW'(BPW - 1);
                state_d       = ST_DUMP_SEND;
            end
            ST_DUMP_SEND: state_d = ST_DUMP_WAIT;
            ST_DUMP_WAIT: begin
                if (ser_done) begin
                    if (byte_cnt_q != '0) begin
                        byte_cnt_d    = byte_cnt_q - BCW'(1);
                        ser_send_word = 1'b1;
                        state_d       = ST_DUMP_SEND;
                    end else if (word_cnt_q != '0) begin
                        word_cnt_d = word_cnt_q - ADDR'(1);
                        rd_addr_d  = rd_addr_q + ADDR'(1);
                        state_d    = ST_DUMP_FETCH;
                    end else begin
                        ser_send_csum = 1'b1;
                        state_d       = ST_SEND_CSUM;
                    end
                end
            end
            ST_SEND_CSUM: begin
                if (ser_done) begin
                    rd_addr_d = '0;
                    ser_clear = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (ser_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            src_q        <= SRC_RB;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            rd_addr_q    <= '0;
            im_cnt_q     <= '0;
            im_wr_en_q   <= 1'b0;
            im_wr_addr_q <= '0;
            im_wr_data_q <= '0;
            cpu_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            rd_addr_q    <= rd_addr_d;
            im_cnt_q     <= im_cnt_d;
            im_wr_en_q   <= im_wr_en_d;
            im_wr_addr_q <= im_wr_addr_d;
            im_wr_data_q <= im_wr_data_d;
            cpu_enable_q <= cpu_enable_d;
        end
    end

    debug_tx_serializer #(
        .BYTE  (BYTE),
        .DWORD (DWORD)
    ) u_tx_ser (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (ser_load),
        .i_word      (dump_word),
        .i_send_word (ser_send_word),
        .i_send_csum (ser_send_csum),
        .i_send_err  (ser_send_err),
        .i_clear     (ser_clear),
        .i_tx_done   (uart.tx_done),
        .o_tx_start  (uart.tx_start),
        .o_tx_data   (uart.tx_data),
        .o_done      (ser_done)
    );

    assign o_im_wr_en   = im_wr_en_q;
    assign o_im_wr_addr = im_wr_addr_q;
    assign o_im_wr_data = im_wr_data_q;
    assign o_cpu_enable = cpu_enable_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_state      = NB_ST'(state_q);

endmodule

// File: tb/tb_debug_link_ctrl.sv
// Directed bench for debug_link_ctrl: a UART responder answers every tx_start
// with tx_done three cycles later while scenario tasks drive commands.
module tb_debug_link_ctrl;

    localparam logic [9:0] E_IDLE  = 10'h001;
    localparam logic [9:0] E_LOAD  = 10'h002;
    localparam logic [9:0] E_RUN   = 10'h004;
    localparam logic [9:0] E_SWAIT = 10'h008;
    localparam logic [9:0] E_SEXEC = 10'h010;
    localparam logic [9:0] E_FETCH = 10'h020;
    localparam logic [9:0] E_SEND  = 10'h040;
    localparam logic [9:0] E_ERR   = 10'h200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        im_wr_en;
    logic [7:0]  im_wr_addr;
    logic [7:0]  im_wr_data;
    logic        cpu_halt;
    logic        cpu_enable;
    logic [4:0]  rd_addr;
    logic [31:0] rb_data;
    logic [31:0] dm_data;
    logic [31:0] pc;
    logic [9:0]  state;

    int errors = 0;
    int checks = 0;

    logic [7:0] txq[$];
    logic       resp_busy;
    int         resp_wait;
    logic [7:0] resp_held;

    always #5 clk = ~clk;

    debug_link_ctrl_if #(.BYTE(8)) uart_if ();

    assign rb_data = 32'h01020304 + 32'(rd_addr);
    assign dm_data = 32'hA55A0F00 ^ (32'(rd_addr) * 32'h00030107);

    debug_link_ctrl dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .uart         (uart_if),
        .o_im_wr_en   (im_wr_en),
        .o_im_wr_addr (im_wr_addr),
        .o_im_wr_data (im_wr_data),
        .i_cpu_halt   (cpu_halt),
        .o_cpu_enable (cpu_enable),
        .o_rd_addr    (rd_addr),
        .i_rb_data    (rb_data),
        .i_dm_data    (dm_data),
        .i_pc         (pc),
        .o_state      (state)
    );

    function automatic logic [31:0] exp_word(input int src, input int a);
        case (src)
            0:       return 32'h01020304 + 32'(a);
            1:       return 32'hA55A0F00 ^ (32'(a) * 32'h00030107);
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // One clock step; also plays the UART transmitter side.
    task automatic tick();
        @(negedge clk);
        uart_if.tx_done = 1'b0;
        if (!rst_n) begin
            resp_busy = 1'b0;
        end else if (resp_busy) begin
            checks++;
            if (uart_if.tx_start !== 1'b0 || uart_if.tx_data !== resp_held) begin
                errors++;
                $display("FAIL tx_hold: start=%0b data=%h, required start=0 data=%h",
                         uart_if.tx_start, uart_if.tx_data, resp_held);
            end
            resp_wait--;
            if (resp_wait == 0) begin
                uart_if.tx_done = 1'b1;
                resp_busy = 1'b0;
            end
        end else if (uart_if.tx_start === 1'b1) begin
            txq.push_back(uart_if.tx_data);
            resp_held = uart_if.tx_data;
            resp_busy = 1'b1;
            resp_wait = 3;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_if.rx_done = 1'b1;
        uart_if.rx_data = b;
        tick();
        uart_if.rx_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (state !== E_IDLE && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (state !== E_IDLE) begin
            errors++;
            $display("FAIL wait_idle: state=%h after %0d cycles, required %h", state, n, E_IDLE);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (state !== E_IDLE || im_wr_en !== 1'b0 || im_wr_addr !== 8'h00 ||
            im_wr_data !== 8'h00 || cpu_enable !== 1'b0 || rd_addr !== 5'd0 ||
            uart_if.tx_start !== 1'b0 || uart_if.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL %s: state=%h wr=%0b/%h/%h en=%0b addr=%0d tx=%0b/%h, required state=001 all others 0",
                     name, state, im_wr_en, im_wr_addr, im_wr_data, cpu_enable, rd_addr,
                     uart_if.tx_start, uart_if.tx_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("after_reset_release");
    endtask

    task automatic test_load_im();
        int pulses = 0;
        send_byte(8'h01);
        checks++;
        if (state !== E_LOAD) begin
            errors++;
            $display("FAIL load_enter: state=%h, required %h", state, E_LOAD);
        end
        for (int b = 0; b < 256; b++) begin
            logic [7:0] b8;
            b8 = 8'(b);
            send_byte(b8);
            if (im_wr_en === 1'b1) pulses++;
            checks++;
            if (im_wr_en !== 1'b1 || im_wr_addr !== b8 || im_wr_data !== b8 ||
                state !== ((b == 255) ? E_IDLE : E_LOAD)) begin
                errors++;
                $display("FAIL load_byte%0d: wr=%0b addr=%h data=%h state=%h, required wr=1 addr=%h data=%h",
                         b, im_wr_en, im_wr_addr, im_wr_data, state, b8, b8);
            end
            tick();
            checks++;
            if (im_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL load_pulse%0d: wr=%0b, required 0", b, im_wr_en);
            end
        end
        checks++;
        if (pulses != 256) begin
            errors++;
            $display("FAIL load_count: pulses=%0d, required 256", pulses);
        end
    endtask

    task automatic test_run();
        int en_cnt = 0;
        txq.delete();
        send_byte(8'h02);
        for (int i = 1; i <= 60; i++) begin
            if (cpu_enable === 1'b1) en_cnt++;
            if (i == 50) cpu_halt = 1'b1;
            if (i == 10) begin
                uart_if.rx_done = 1'b1;
                uart_if.rx_data = 8'h05;
            end
            if (i == 11) uart_if.rx_done = 1'b0;
            tick();
        end
        checks++;
        if (en_cnt != 50) begin
            errors++;
            $display("FAIL run_enable_cycles: got %0d, required 50", en_cnt);
        end
        checks++;
        if (state !== E_IDLE || cpu_enable !== 1'b0 || txq.size() != 0) begin
            errors++;
            $display("FAIL run_exit: state=%h en=%0b tx_bytes=%0d, required state=%h en=0 tx_bytes=0",
                     state, cpu_enable, txq.size(), E_IDLE);
        end
        cpu_halt = 1'b0;
        tick();
    endtask

    task automatic test_step();
        send_byte(8'h03);
        checks++;
        if (state !== E_SWAIT) begin
            errors++;
            $display("FAIL step_enter: state=%h, required %h", state, E_SWAIT);
        end
        for (int s = 0; s < 3; s++) begin
            send_byte(8'h07);
            checks++;
            if (cpu_enable !== 1'b1 || state !== E_SEXEC) begin
                errors++;
                $display("FAIL step%0d_exec: en=%0b state=%h, required en=1 state=%h",
                         s, cpu_enable, state, E_SEXEC);
            end
            tick();
            checks++;
            if (cpu_enable !== 1'b0 || state !== E_SWAIT) begin
                errors++;
                $display("FAIL step%0d_back: en=%0b state=%h, required en=0 state=%h",
                         s, cpu_enable, state, E_SWAIT);
            end
            tick();
        end
        cpu_halt = 1'b1;
        send_byte(8'h07);
        tick();
        checks++;
        if (cpu_enable !== 1'b0 || state !== E_SWAIT) begin
            errors++;
            $display("FAIL step_halted: en=%0b state=%h, required en=0 state=%h",
                     cpu_enable, state, E_SWAIT);
        end
        cpu_halt = 1'b0;
        send_byte(8'h02);
        checks++;
        if (state !== E_SWAIT || cpu_enable !== 1'b0) begin
            errors++;
            $display("FAIL step_ignore: state=%h en=%0b, required state=%h en=0",
                     state, cpu_enable, E_SWAIT);
        end
        send_byte(8'h08);
        checks++;
        if (state !== E_IDLE) begin
            errors++;
            $display("FAIL step_exit: state=%h, required %h", state, E_IDLE);
        end
    endtask

    task automatic test_dump(input logic [7:0] cmd, input int src, input int words);
        logic [7:0]  exp_q[$];
        logic [31:0] w;
        logic [7:0]  eb;
        logic [7:0]  csum;
        csum = 8'h00;
        for (int a = 0; a < words; a++) begin
            w = exp_word(src, a);
            for (int k = 3; k >= 0; k--) begin
                eb = w[8*k +: 8];
                exp_q.push_back(eb);
                csum = csum ^ eb;
            end
        end
        exp_q.push_back(csum);
        txq.delete();
        send_byte(cmd);
        checks++;
        if (state !== E_FETCH || uart_if.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL dump%0d_fetch: state=%h start=%0b, required state=%h start=0",
                     src, state, uart_if.tx_start, E_FETCH);
        end
        tick();
        checks++;
        if (state !== E_SEND || uart_if.tx_start !== 1'b1 || uart_if.tx_data !== exp_q[0]) begin
            errors++;
            $display("FAIL dump%0d_first: state=%h start=%0b data=%h, required state=%h start=1 data=%h",
                     src, state, uart_if.tx_start, uart_if.tx_data, E_SEND, exp_q[0]);
        end
        repeat (8) tick();
        send_byte(8'h01);
        wait_idle(4000);
        checks++;
        if (txq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL dump%0d_count: bytes=%0d, required %0d", src, txq.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL dump%0d_byte%0d: got %h, required %h", src, i, txq[i], exp_q[i]);
            end
        end
        tick();
        checks++;
        if (rd_addr !== 5'd0 || state !== E_IDLE || im_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL dump%0d_end: addr=%0d state=%h wr=%0b, required addr=0 state=%h wr=0",
                     src, rd_addr, state, im_wr_en, E_IDLE);
        end
    endtask

    task automatic test_pc_csum();
        test_dump(8'h06, 2, 1);
        checks++;
        if (txq.size() != 5 || txq[4] !== 8'h22) begin
            errors++;
            $display("FAIL pc_checksum: bytes=%0d last=%h, required 5 bytes ending 22",
                     txq.size(), (txq.size() > 0) ? txq[txq.size()-1] : 8'h00);
        end
    endtask

    task automatic test_error();
        txq.delete();
        send_byte(8'h5A);
        checks++;
        if (state !== E_ERR) begin
            errors++;
            $display("FAIL err_enter: state=%h, required %h", state, E_ERR);
        end
        wait_idle(100);
        checks++;
        if (txq.size() != 1 || txq[0] !== 8'hEE) begin
            errors++;
            $display("FAIL err_byte: bytes=%0d first=%h, required 1 byte EE",
                     txq.size(), (txq.size() > 0) ? txq[0] : 8'h00);
        end
    endtask

    task automatic test_reset_mid_dump();
        int qs;
        txq.delete();
        send_byte(8'h05);
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_dump");
        qs = txq.size();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        checks++;
        if (txq.size() != qs || state !== E_IDLE) begin
            errors++;
            $display("FAIL reset_no_resend: bytes=%0d state=%h, required bytes=%0d state=%h",
                     txq.size(), state, qs, E_IDLE);
        end
    endtask

    initial begin
        uart_if.rx_done = 1'b0;
        uart_if.rx_data = 8'h00;
        uart_if.tx_done = 1'b0;
        cpu_halt  = 1'b0;
        pc        = 32'hDEADBEEF;
        resp_busy = 1'b0;
        resp_wait = 0;
        resp_held = 8'h00;

        test_reset();
        test_load_im();
        test_run();
        test_step();
        test_dump(8'h04, 0, 32);
        test_dump(8'h05, 1, 32);
        test_pc_csum();
        test_error();
        test_reset_mid_dump();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
